// File: rtl/imem_loader.sv
// Byte-stream loader for the 256-word instruction memory.
// Packs bytes little-endian into words and holds the CPU in reset until loaded.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W:0]   load_q;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;

    logic start_bad, start_zero, start_ok, last_word;

    assign start_bad  = start && (load_words > DEPTH_W);
    assign start_zero = start && (load_words == '0);
    assign start_ok   = start && !start_bad && !start_zero;
    assign last_word  = (word_cnt + 1'b1) == load_q;

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = COLLECT;
            end
            COLLECT: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                state_nxt = last_word ? IDLE : COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            load_q    <= '0;
            word_cnt  <= '0;
            addr      <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_bad) begin
                        err <= 1'b1;
                    end else if (start_zero) begin
                        done      <= 1'b1;
                        err       <= 1'b0;
                        cpu_reset <= 1'b0;
                    end else if (start_ok) begin
                        load_q    <= load_words;
                        word_cnt  <= '0;
                        addr      <= '0;
                        byte_cnt  <= '0;
                        asm_q     <= '0;
                        err       <= 1'b0;
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= byte_in;
                            2'd1: asm_q[15:8]  <= byte_in;
                            2'd2: asm_q[23:16] <= byte_in;
                            default: begin
                                // Output regs latch here so they hold between strobes
                                mem_waddr <= addr;
                                mem_wdata <= {byte_in, asm_q};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    addr     <= addr + 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                    byte_cnt <= '0;
                    if (last_word) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the 256-word instruction memory that the processor fetches from.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes the words into consecutive memory addresses starting at word 0.
- Holds the processor in reset until the load completes.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory.
- DEPTH, 256, number of 32-bit words in the memory (2**ADDR_W).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  load request; sampled only in IDLE.
- load_words  input  ADDR_W+1  number of words to load; latched on accepted start.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_waddr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  word being written.
- busy  output  1  load in progress.
- done  output  1  last load completed; level signal.
- err  output  1  last start was rejected (load_words > DEPTH); level signal.
- cpu_reset  output  1  active-high reset to the processor.

Behaviour:
- Reset (reset==0 at posedge):
  - State IDLE.
  - byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_reset=1.
  - Internal byte counter, word counter and assembly register cleared.
  - Reset mid-load discards any partial word. Words already written stay in memory.
- FSM states: IDLE, COLLECT, WRITE.
- IDLE:
  - byte_ready=0, busy=0.
  - On start=1:
    - load_words > DEPTH: err<=1, done unchanged, stay IDLE.
    - load_words == 0: done<=1, err<=0, cpu_reset<=0, stay IDLE.
    - Otherwise: latch load_words, clear address/byte/word counters, err<=0, done<=0, cpu_reset<=1, busy<=1, go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready at posedge.
  - Byte k (k=0..3) of a word goes to bits [8k+7:8k]; first byte is the LSB.
  - When the 4th byte is accepted, go to WRITE.
  - byte_valid low simply stalls; there is no timeout.
- WRITE:
  - byte_ready=0.
  - mem_we=1 for exactly this one cycle, with mem_waddr = current word address and mem_wdata = assembled word.
  - Next cycle: address+1, word count+1, byte counter to 0.
    - If word count now equals load_words: busy<=0, done<=1, cpu_reset<=0, go to IDLE.
    - Otherwise go to COLLECT.
- Throughput: minimum 5 cycles per word (4 accept cycles + 1 write cycle).
  - byte_ready rises the cycle after start is accepted.
- Address wrap: with load_words==DEPTH the last write goes to address 255. The address counter may wrap to 0 internally after that write; no further write occurs.
- start while busy is ignored. load_words changes during a load have no effect.
- mem_waddr/mem_wdata hold their last values when mem_we=0.
- cpu_reset stays 1 from reset until the first successful load (or zero-length load). It is reasserted on every accepted start.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> byte_ready=0, mem_we=0, busy=0, done=0, err=0, cpu_reset=1.
- Two-word load, continuous valid: start, load_words=2; bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD.
  - Write addr0=0x44332211, then addr1=0xDDCCBBAA, each mem_we one cycle, 5 cycles apart.
  - Then done=1, cpu_reset=0, busy=0.
- Backpressure/gaps: same load with byte_valid toggling every other cycle -> identical write data and addresses, no byte lost or duplicated, byte_ready=0 during WRITE.
- Boundaries:
  - load_words=0 -> done=1, cpu_reset=0 next cycle, no mem_we.
  - load_words=257 -> err=1, stays IDLE, cpu_reset unchanged.
  - load_words=256 with incrementing words -> last write at addr 255, exactly 256 strobes.
- Reset mid-load: assert reset=0 after 2 bytes of word 1 -> all outputs return to reset values. A new 1-word load then writes addr 0 with the fresh data.
- start pulsed during an active load -> ignored, load_words unchanged, load completes normally.
